// File: rtl/vx_writeback_arb.sv
// Commit-side writeback arbiter: round-robin over the commit ports, with a lock
// that holds multi-beat packets together, one registered writeback stream, conflict counter.
module vx_writeback_arb #(
  parameter int CORE_ID     = 0,
  parameter int NUM_SRC     = 5,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_SRC-1:0]              cmt_valid,
  output logic [NUM_SRC-1:0]              cmt_ready,
  input  logic [NUM_SRC-1:0]              cmt_wb,
  input  logic [NUM_SRC-1:0]              cmt_eop,
  input  logic [NUM_SRC*NW_BITS-1:0]      cmt_wid,
  input  logic [NUM_SRC*NUM_THREADS-1:0]  cmt_tmask,
  input  logic [NUM_SRC*32-1:0]           cmt_PC,
  input  logic [NUM_SRC*5-1:0]            cmt_rd,
  input  logic [NUM_SRC*NUM_THREADS*32-1:0] cmt_data,
  output logic                            wb_valid,
  output logic [NW_BITS-1:0]              wb_wid,
  output logic [NUM_THREADS-1:0]          wb_tmask,
  output logic [31:0]                     wb_PC,
  output logic [4:0]                      wb_rd,
  output logic [NUM_THREADS*32-1:0]       wb_data,
  output logic                            wb_eop,
  output logic [43:0]                     perf_wb_conflicts
);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int DW    = NUM_THREADS * 32;

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [NW_BITS-1:0]     wb_wid_q, wb_wid_d;
  logic [NUM_THREADS-1:0] wb_tmask_q, wb_tmask_d;
  logic [31:0]            wb_pc_q, wb_pc_d;
  logic [4:0]             wb_rd_q, wb_rd_d;
  logic [DW-1:0]          wb_data_q, wb_data_d;
  logic                   wb_eop_q, wb_eop_d;
  logic [43:0]            perf_q, perf_d;

  logic [NUM_SRC-1:0]     elig, grant_oh;
  logic                   grant_any, grant_eop;
  logic [IDX_W-1:0]       grant_idx, idx;
  logic [IDX_W:0]         sum;

  always_comb begin
    elig = cmt_valid & cmt_wb;
    if (state_q == LOCKED) elig = elig & (NUM_SRC'(1) << lock_idx_q);

    // Round-robin search starting at rr_ptr; sum is one bit wider so the wrap never overflows.
    grant_oh  = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_SRC)) sum = sum - (IDX_W+1)'(NUM_SRC);
      idx = sum[IDX_W-1:0];
      if (!grant_any && elig[idx]) begin
        grant_any     = 1'b1;
        grant_idx     = idx;
        grant_oh[idx] = 1'b1;
      end
    end

    cmt_ready = (cmt_valid & ~cmt_wb) | grant_oh;

    wb_valid_d = grant_any;
    wb_wid_d   = wb_wid_q;
    wb_tmask_d = wb_tmask_q;
    wb_pc_d    = wb_pc_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_eop_d   = wb_eop_q;
    grant_eop  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_oh[i]) begin
        wb_wid_d   = cmt_wid[i*NW_BITS +: NW_BITS];
        wb_tmask_d = cmt_tmask[i*NUM_THREADS +: NUM_THREADS];
        wb_pc_d    = cmt_PC[i*32 +: 32];
        wb_rd_d    = cmt_rd[i*5 +: 5];
        wb_data_d  = cmt_data[i*DW +: DW];
        wb_eop_d   = cmt_eop[i];
        grant_eop  = cmt_eop[i];
      end
    end

    rr_ptr_d   = rr_ptr_q;
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    if (grant_any) begin
      if (grant_eop) begin
        rr_ptr_d = (grant_idx == IDX_W'(NUM_SRC-1)) ? '0 : grant_idx + 1'b1;
        state_d  = UNLOCKED;
      end else begin
        state_d    = LOCKED;
        lock_idx_d = grant_idx;
      end
    end

    perf_d = perf_q;
    if ($countones(elig) >= 2 && perf_q != '1) perf_d = perf_q + 44'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= UNLOCKED;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_wid_q   <= '0;
      wb_tmask_q <= '0;
      wb_pc_q    <= '0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_eop_q   <= 1'b0;
      perf_q     <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_wid_q   <= wb_wid_d;
      wb_tmask_q <= wb_tmask_d;
      wb_pc_q    <= wb_pc_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_eop_q   <= wb_eop_d;
      perf_q     <= perf_d;
    end
  end

  assign wb_valid          = wb_valid_q;
  assign wb_wid            = wb_wid_q;
  assign wb_tmask          = wb_tmask_q;
  assign wb_PC             = wb_pc_q;
  assign wb_rd             = wb_rd_q;
  assign wb_data           = wb_data_q;
  assign wb_eop            = wb_eop_q;
  assign perf_wb_conflicts = perf_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(grant_oh))
        else $error("core%0d writeback: multiple grants %b", CORE_ID, grant_oh);
      assert (state_q != LOCKED || (grant_oh & ~(NUM_SRC'(1) << lock_idx_q)) == '0)
        else $error("core%0d writeback: grant %b escapes lock %0d", CORE_ID, grant_oh, lock_idx_q);
    end
  end
`endif
endmodule

// File: tb/tb_vx_writeback_arb.sv
// Scoreboard bench for vx_writeback_arb: expected beats queued when a grant is
// expected, popped and compared when wb_valid appears one cycle later.
module tb_vx_writeback_arb;
  localparam int NS = 5, NT = 4, NWB = 2;

  logic              clk = 1'b0, reset = 1'b1;
  logic [NS-1:0]     cmt_valid = '0, cmt_ready, cmt_wb = '0, cmt_eop = '0;
  logic [NS*NWB-1:0] cmt_wid = '0;
  logic [NS*NT-1:0]  cmt_tmask = '0;
  logic [NS*32-1:0]  cmt_PC = '0;
  logic [NS*5-1:0]   cmt_rd = '0;
  logic [NS*NT*32-1:0] cmt_data = '0;
  logic              wb_valid, wb_eop;
  logic [NWB-1:0]    wb_wid;
  logic [NT-1:0]     wb_tmask;
  logic [31:0]       wb_PC;
  logic [4:0]        wb_rd;
  logic [NT*32-1:0]  wb_data;
  logic [43:0]       perf_wb_conflicts;

  typedef struct packed {
    logic [NWB-1:0]   wid;
    logic [NT-1:0]    tmask;
    logic [31:0]      pc;
    logic [4:0]       rd;
    logic [NT*32-1:0] data;
    logic             eop;
  } beat_t;

  beat_t sb[$];
  int n_chk = 0, n_err = 0;

  vx_writeback_arb #(.CORE_ID(0), .NUM_SRC(NS), .NUM_THREADS(NT), .NW_BITS(NWB)) dut (
    .clk(clk), .reset(reset),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_wb(cmt_wb), .cmt_eop(cmt_eop),
    .cmt_wid(cmt_wid), .cmt_tmask(cmt_tmask), .cmt_PC(cmt_PC), .cmt_rd(cmt_rd),
    .cmt_data(cmt_data),
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_tmask(wb_tmask), .wb_PC(wb_PC),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_eop(wb_eop),
    .perf_wb_conflicts(perf_wb_conflicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic w, input logic e,
                         input logic [4:0] rd, input logic [31:0] d, input logic [3:0] tm,
                         input logic [31:0] inc);
    cmt_valid[i] = v;
    cmt_wb[i]    = w;
    cmt_eop[i]   = e;
    cmt_wid[i*NWB +: NWB]  = NWB'(i);
    cmt_tmask[i*NT +: NT]  = tm;
    cmt_PC[i*32 +: 32]     = 32'h1000 * (i + 1) + 32'(rd);
    cmt_rd[i*5 +: 5]       = rd;
    for (int l = 0; l < NT; l++) cmt_data[(i*NT + l)*32 +: 32] = d + inc * l;
  endtask

  function automatic beat_t src_beat(input int i);
    beat_t b;
    b.wid   = cmt_wid[i*NWB +: NWB];
    b.tmask = cmt_tmask[i*NT +: NT];
    b.pc    = cmt_PC[i*32 +: 32];
    b.rd    = cmt_rd[i*5 +: 5];
    b.data  = cmt_data[i*NT*32 +: NT*32];
    b.eop   = cmt_eop[i];
    return b;
  endfunction

  // One cycle: check ready combinationally, queue the expected beat, then check output after the edge.
  task automatic cyc(input string tag, input logic [NS-1:0] exp_rdy, input int exp_g);
    beat_t b, act;
    #1;
    chk({tag, "_ready"}, 192'(cmt_ready), 192'(exp_rdy));
    if (exp_g >= 0) sb.push_back(src_beat(exp_g));
    @(posedge clk); #1;
    chk({tag, "_wb_valid"}, 192'(wb_valid), 192'(exp_g >= 0));
    if (wb_valid) begin
      act = {wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop};
      if (sb.size() == 0) chk({tag, "_sb_empty"}, 192'(1), 192'(0));
      else begin
        b = sb.pop_front();
        chk({tag, "_beat"}, 192'(act), 192'(b));
      end
    end
  endtask

  task automatic clr_all();
    cmt_valid = '0; cmt_wb = '0; cmt_eop = '0;
  endtask

  task automatic do_reset();
    clr_all();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 192'(wb_valid), 192'(0));
    chk("rst_payload", 192'({wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop}), 192'(0));
    chk("rst_perf", 192'(perf_wb_conflicts), 192'(0));

    // ALU alone, same data on every lane
    set_src(0, 1, 1, 1, 5'd5, 32'h11, 4'hF, 32'h0);
    cyc("alu", 5'b00001, 0);
    clr_all();
    // rr_ptr is now 1: LSU must beat ALU
    set_src(0, 1, 1, 1, 5'd6, 32'h20, 4'hF, 32'h100);
    set_src(1, 1, 1, 1, 5'd7, 32'h30, 4'h3, 32'h100);
    cyc("ptr1_lsu", 5'b00010, 1);
    cmt_valid[1] = 1'b0;
    cyc("ptr1_alu", 5'b00001, 0);
    clr_all();
    chk("perf_pre", 192'(perf_wb_conflicts), 192'(1));
    do_reset();
    chk("rst2_perf", 192'(perf_wb_conflicts), 192'(0));

    // All five sources from rr_ptr=0: one grant per cycle in index order
    for (int i = 0; i < NS; i++)
      set_src(i, 1, 1, 1, 5'(10 + i), 32'hA0 + 32'(i), (i % 2) ? 4'b0101 : 4'hF, 32'h100);
    for (int k = 0; k < NS; k++) begin
      cyc("all5", NS'(1) << k, k);
      cmt_valid[k] = 1'b0;
    end
    clr_all();
    chk("perf_all5", 192'(perf_wb_conflicts), 192'(4));

    // rr_ptr back to 0; an ALU beat moves it to 1 so LSU leads the packet
    set_src(0, 1, 1, 1, 5'd3, 32'h33, 4'hF, 32'h100);
    cyc("alu_pre", 5'b00001, 0);
    set_src(1, 1, 1, 0, 5'd1, 32'hB1, 4'hF, 32'h100);
    cyc("lsu_b0", 5'b00010, 1);
    set_src(1, 1, 1, 0, 5'd2, 32'hB2, 4'hE, 32'h100);
    cyc("lsu_b1", 5'b00010, 1);
    set_src(1, 1, 1, 1, 5'd3, 32'hB3, 4'hF, 32'h100);
    cyc("lsu_b2", 5'b00010, 1);
    cmt_valid[1] = 1'b0;
    cyc("alu_post", 5'b00001, 0);
    clr_all();
    chk("perf_lock", 192'(perf_wb_conflicts), 192'(5));

    // Lock held across LSU gaps: bubbles, CSR stalls until LSU eop
    set_src(2, 1, 1, 1, 5'd9, 32'hC0, 4'hF, 32'h100);
    set_src(1, 1, 1, 0, 5'd4, 32'hD0, 4'hF, 32'h100);
    cyc("gap_b0", 5'b00010, 1);
    cmt_valid[1] = 1'b0;
    cyc("gap_bub0", 5'b00000, -1);
    cyc("gap_bub1", 5'b00000, -1);
    set_src(1, 1, 1, 1, 5'd8, 32'hD1, 4'hF, 32'h100);
    cyc("gap_b1", 5'b00010, 1);
    cmt_valid[1] = 1'b0;
    cyc("gap_csr", 5'b00100, 2);
    clr_all();
    chk("perf_gap", 192'(perf_wb_conflicts), 192'(6));

    // Drop path alongside a grant, then payload hold and a lone drop
    set_src(3, 1, 0, 1, 5'd20, 32'hE0, 4'hF, 32'h100);
    set_src(4, 1, 1, 1, 5'd21, 32'hF0, 4'h9, 32'h100);
    cyc("drop_gpu", 5'b11000, 4);
    cmt_valid[4] = 1'b0;
    cyc("drop_only", 5'b01000, -1);
    chk("hold_rd", 192'(wb_rd), 192'(21));
    chk("hold_pc", 192'(wb_PC), 192'(32'h5000 + 32'd21));
    clr_all();

    // Reset while locked on LSU with another LSU beat presented
    set_src(1, 1, 1, 0, 5'd12, 32'h77, 4'hF, 32'h100);
    cyc("rl_b0", 5'b00010, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rl_valid", 192'(wb_valid), 192'(0));
    chk("rl_perf", 192'(perf_wb_conflicts), 192'(0));
    reset = 1'b0;
    clr_all();
    set_src(0, 1, 1, 1, 5'd13, 32'h88, 4'hF, 32'h100);
    cyc("rl_alu", 5'b00001, 0);
    clr_all();

    chk("sb_drain", 192'(sb.size()), 192'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/vx_writeback_arb.md
Name: vx_writeback_arb

Overview:
- Commit-side counterpart of the issue stage. Collects completed results from the ALU, LSU, CSR, FPU and GPU commit ports.
- Arbitrates the results round-robin, with a lock that keeps multi-beat packets together.
- Drives the single registered writeback stream consumed by the GPR stage and the scoreboard.
- Also counts arbitration conflicts for the perf pipeline.

Parameters:
- CORE_ID, 0, core index; used only in debug prints.
- NUM_SRC, 5, number of commit sources; index 0=ALU, 1=LSU, 2=CSR, 3=FPU, 4=GPU.
- NUM_THREADS, 4, threads per warp.
- NW_BITS, 2, warp-id width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmt_valid  in  NUM_SRC  per-source commit valid.
- cmt_ready  out  NUM_SRC  per-source accept; a transfer occurs when valid && ready in the same cycle.
- cmt_wb  in  NUM_SRC  result writes the GPR.
- cmt_eop  in  NUM_SRC  last beat of the instruction.
- cmt_wid  in  NUM_SRC*NW_BITS  warp id; source i occupies slice [i*NW_BITS +: NW_BITS].
- cmt_tmask  in  NUM_SRC*NUM_THREADS  thread mask.
- cmt_PC  in  NUM_SRC*32  instruction PC.
- cmt_rd  in  NUM_SRC*5  destination register.
- cmt_data  in  NUM_SRC*NUM_THREADS*32  per-thread results.
- wb_valid  out  1  writeback valid; there is no ready, and the sink always accepts.
- wb_wid  out  NW_BITS  writeback warp id.
- wb_tmask  out  NUM_THREADS  writeback thread mask.
- wb_PC  out  32  writeback PC.
- wb_rd  out  5  writeback destination register.
- wb_data  out  NUM_THREADS*32  writeback data.
- wb_eop  out  1  writeback end of packet.
- perf_wb_conflicts  out  44  cycles with at least 2 eligible requesters and only 1 granted.

Behaviour:
- Drop path
  - A source with cmt_valid=1 and cmt_wb=0 gets cmt_ready=1 in the same cycle, combinationally.
  - It is never output, does not take part in arbitration, and does not affect the lock or the pointer.
- Eligibility
  - Source i is eligible when cmt_valid[i] && cmt_wb[i].
  - When locked, only lock_idx may be eligible.
- Grant
  - At most one eligible source is granted per cycle.
  - Search order is rr_ptr, rr_ptr+1, ... wrapping modulo NUM_SRC.
  - The granted source sees cmt_ready=1; all other wb=1 sources see cmt_ready=0.
- Output register
  - The granted beat is registered and appears on wb_* in the next cycle (latency exactly 1).
  - If nothing is granted, wb_valid=0 next cycle.
  - wb_* payload fields hold their last values while wb_valid=0.
  - Data lanes with tmask=0 pass through unmodified.
- Pointer
  - On a granted beat with eop=1, rr_ptr <= (granted index + 1) mod NUM_SRC.
  - On a granted beat with eop=0, rr_ptr is unchanged.
- Lock FSM (states UNLOCKED and LOCKED)
  - UNLOCKED to LOCKED on a granted beat with eop=0; lock_idx <= granted index.
  - LOCKED to UNLOCKED on a granted beat from lock_idx with eop=1.
  - While LOCKED with lock_idx not valid, no grant is made, a bubble is emitted, and other sources stall.
- Conflict counter
  - Increments by 1 when the eligible count is at least 2.
  - Saturates at all-ones.
- Reset (sync) values
  - wb_valid=0, wb_eop=0, and all wb_* payload fields 0.
  - rr_ptr=0, state UNLOCKED, lock_idx=0, perf_wb_conflicts=0.
  - Reset mid-packet discards the lock; any beat that was in flight is not output.
- Simultaneous events
  - A drop (wb=0) on source j is accepted in the same cycle as a grant to source k≠j.
- Assertions (simulation only)
  - At most one bit of the wb=1 grant vector is set per cycle.
  - While LOCKED, no grant goes to any index other than lock_idx.

Test Plan:
- Reset, then ALU alone: valid=1, wb=1, eop=1, rd=5, data=32'h11 on every lane -> cmt_ready[0]=1 at t; at t+1 wb_valid=1, wb_rd=5, wb_data lanes=32'h11; rr_ptr=1.
- All 5 sources valid, wb=1, eop=1, held for 5 cycles from rr_ptr=0 -> grant order 0,1,2,3,4; wb_valid high for 5 consecutive cycles; perf_wb_conflicts=4.
- LSU 3-beat packet (eop=0,0,1) with ALU valid throughout -> LSU beats are output back-to-back, then the ALU beat; ALU cmt_ready=0 for 3 cycles.
- LSU beat eop=0 granted, then LSU valid=0 for 2 cycles while CSR valid -> 2 bubble cycles (wb_valid=0); CSR granted only after LSU sends eop=1.
- FPU valid with wb=0 while GPU valid with wb=1 -> both cmt_ready=1 in the same cycle; only the GPU beat appears on wb_*.
- Reset asserted while LOCKED on LSU -> next cycle wb_valid=0 and state UNLOCKED; ALU is granted immediately after reset deasserts.
